// File: rtl/tff_seq_ctrl.sv
// rtl/tff_seq_ctrl.sv - step sequencer generating toggle enables for a WIDTH-bit T-FF bank
// Optional abort input enabled by defining TFF_SEQ_ABORT_EN.
module tff_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] steps,
    input  logic [WIDTH-1:0] load_val,
`ifdef TFF_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   ld_q, ld_d;
    logic [WIDTH-1:0]   bank_q, bank_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               abort_act;
    logic [WIDTH-1:0]   up_t, dn_t;

`ifdef TFF_SEQ_ABORT_EN
    assign abort_act = abort && (state_q == ST_RUN);
`else
    assign abort_act = 1'b0;
`endif

    // Carry/borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & bank_q[i-1];
            dn_t[i] = dn_t[i-1] & ~bank_q[i-1];
        end
    end

    always_comb begin
        t_vec = '0;
        if (state_q == ST_RUN && !abort_act) begin
            case (mode_q)
                MODE_UP:   t_vec = up_t;
                MODE_DOWN: t_vec = dn_t;
                MODE_LOAD: t_vec = bank_q ^ ld_q;
                default:   t_vec = {WIDTH{1'b1}};
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ld_d    = ld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bank_d  = bank_q ^ t_vec;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    mode_d = mode;
                    ld_d   = load_val;
                    if (steps == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        // A load reaches its target in one edge, so it always runs once.
                        cnt_d   = (mode == MODE_LOAD) ? CNT_W'(1) : steps;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (abort_act || cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            ld_q    <= '0;
            bank_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ld_q    <= ld_d;
            bank_q  <= bank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = bank_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// tb/tb_tff_seq_ctrl.sv - directed self-checking bench for tff_seq_ctrl (WIDTH=4, CNT_W=8)
module tb_tff_seq_ctrl;

    logic       clk;
    logic       clr;
    logic       start;
    logic [1:0] mode;
    logic [7:0] steps;
    logic [3:0] load_val;
`ifdef TFF_SEQ_ABORT_EN
    logic       abort;
`endif
    logic [3:0] t_vec;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    tff_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .mode     (mode),
        .steps    (steps),
        .load_val (load_val),
`ifdef TFF_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .t_vec    (t_vec),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] m, input logic [7:0] n, input logic [3:0] lv);
        start    = 1'b1;
        mode     = m;
        steps    = n;
        load_val = lv;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 300) begin
            tick();
            cycles++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done timeout: done=%b required 1", done);
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (3) tick();
        checks++;
        if ({q, t_vec, busy, done} !== 10'b0) begin
            failures++;
            $display("FAIL reset_hold: q=%h t=%h busy=%b done=%b required 0 0 0 0", q, t_vec, busy, done);
        end
        clr = 1'b1;
        repeat (2) tick();
        checks++;
        if ({q, t_vec, busy, done} !== 10'b0) begin
            failures++;
            $display("FAIL reset_release: q=%h t=%h busy=%b done=%b required 0 0 0 0", q, t_vec, busy, done);
        end
    endtask

    task automatic test_up();
        start_op(2'b00, 8'd5, 4'h0);
        checks++;
        if (busy !== 1'b1 || q !== 4'h0 || t_vec !== 4'h1) begin
            failures++;
            $display("FAIL up_accept: busy=%b q=%h t=%h required 1 0 1", busy, q, t_vec);
        end
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL up_busy step %0d: busy=%b done=%b required 1 0", i, busy, done);
                end
            end
            tick();
            checks++;
            if (q !== 4'(i)) begin
                failures++;
                $display("FAIL up_q step %0d: q=%h required %h", i, q, 4'(i));
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL up_done: done=%b busy=%b required 1 0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 4'h5) begin
            failures++;
            $display("FAIL up_after: done=%b busy=%b q=%h required 0 0 5", done, busy, q);
        end
    endtask

    task automatic test_load_down();
        int cyc;
        start_op(2'b10, 8'd7, 4'hA);
        tick();
        checks++;
        if (q !== 4'hA || done !== 1'b1) begin
            failures++;
            $display("FAIL load: q=%h done=%b required a 1", q, done);
        end
        tick();
        start_op(2'b01, 8'd12, 4'h0);
        wait_done(cyc);
        checks++;
        if (cyc !== 12 || q !== 4'hE) begin
            failures++;
            $display("FAIL down_wrap: cycles=%0d q=%h required 12 e", cyc, q);
        end
        tick();
    endtask

    task automatic test_wrap_toggle_all();
        int cyc;
        start_op(2'b10, 8'd1, 4'hF);
        wait_done(cyc);
        tick();
        start_op(2'b00, 8'd1, 4'h0);
        wait_done(cyc);
        checks++;
        if (q !== 4'h0 || cyc !== 1) begin
            failures++;
            $display("FAIL up_wrap: q=%h cycles=%0d required 0 1", q, cyc);
        end
        tick();
        start_op(2'b10, 8'd1, 4'h3);
        wait_done(cyc);
        tick();
        start_op(2'b11, 8'd3, 4'h0);
        checks++;
        if (t_vec !== 4'hF) begin
            failures++;
            $display("FAIL toggle_all_t: t=%h required f", t_vec);
        end
        wait_done(cyc);
        checks++;
        if (q !== 4'hC || cyc !== 3) begin
            failures++;
            $display("FAIL toggle_all: q=%h cycles=%0d required c 3", q, cyc);
        end
        tick();
    endtask

    task automatic test_edge_cases();
        int cyc;
        start_op(2'b00, 8'd0, 4'h0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 4'hC || t_vec !== 4'h0) begin
            failures++;
            $display("FAIL steps0: done=%b busy=%b q=%h t=%h required 1 0 c 0", done, busy, q, t_vec);
        end
        tick();
        checks++;
        if (done !== 1'b0 || q !== 4'hC) begin
            failures++;
            $display("FAIL steps0_after: done=%b q=%h required 0 c", done, q);
        end
        start_op(2'b00, 8'd4, 4'h0);
        tick();
        start    = 1'b1;
        mode     = 2'b10;
        steps    = 8'd1;
        load_val = 4'h5;
        tick();
        start    = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc !== 2 || q !== 4'h0) begin
            failures++;
            $display("FAIL start_in_run: cycles=%0d q=%h required 2 0", cyc, q);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL no_queue: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        start_op(2'b00, 8'd8, 4'h0);
        repeat (3) tick();
        checks++;
        if (q !== 4'h3) begin
            failures++;
            $display("FAIL mid_run_pre: q=%h required 3", q);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (q !== 4'h0 || busy !== 1'b0 || t_vec !== 4'h0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_reset: q=%h busy=%b t=%h done=%b required 0 0 0 0", q, busy, t_vec, done);
        end
        seen_done = 0;
        repeat (2) begin
            tick();
            if (done) seen_done++;
        end
        clr = 1'b1;
        repeat (3) begin
            tick();
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || q !== 4'h0) begin
            failures++;
            $display("FAIL mid_run_idle: activity=%0d q=%h required 0 0", seen_done, q);
        end
    endtask

`ifdef TFF_SEQ_ABORT_EN
    task automatic test_abort();
        start_op(2'b00, 8'd8, 4'h0);
        repeat (3) tick();
        abort = 1'b1;
        #1;
        checks++;
        if (t_vec !== 4'h0 || q !== 4'h3) begin
            failures++;
            $display("FAIL abort_t: t=%h q=%h required 0 3", t_vec, q);
        end
        tick();
        abort = 1'b0;
        checks++;
        if (q !== 4'h3 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_done: q=%h done=%b busy=%b required 3 1 0", q, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || q !== 4'h3) begin
            failures++;
            $display("FAIL abort_after: done=%b q=%h required 0 3", done, q);
        end
    endtask
`endif

    initial begin
        clr      = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        steps    = 8'd0;
        load_val = 4'h0;
`ifdef TFF_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        test_reset();
        test_up();
        test_load_down();
        test_wrap_toggle_all();
        test_edge_cases();
        test_reset_mid_run();
`ifdef TFF_SEQ_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
